// File: rtl/alu.sv
// Two-operand integer ALU (add, sub, and, or) with a one-cycle registered
// result and sign / signed-overflow / zero status flags.
module alu #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  input  logic [1:0]            control,
  output logic [data_width-1:0] R,
  output logic                  ovflag,
  output logic                  signflag,
  output logic                  zeroflag
);

  localparam int MSB = data_width - 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic signed [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

  // Two's-complement overflow from operand and result sign bits only.
  function automatic logic overflow(input logic [1:0] op, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic ov;
    ov = 1'b0;
    case (op)
      OP_ADD:  ov = (a_msb == b_msb) && (r_msb != a_msb);
      OP_SUB:  ov = (a_msb != b_msb) && (r_msb != a_msb);
      default: ov = 1'b0;
    endcase
    return ov;
  endfunction

  logic signed [data_width-1:0] a_s;
  logic signed [data_width-1:0] b_s;
  logic signed [data_width-1:0] res;
  logic                         ov;

  assign a_s = A;
  assign b_s = B;

  always_comb begin
    res = '0;
    case (control)
      OP_ADD:  res = a_s + b_s;
      OP_SUB:  res = a_s + ~b_s + ONE;
      OP_AND:  res = a_s & b_s;
      OP_OR:   res = a_s | b_s;
      default: res = '0;
    endcase
    ov = overflow(control, a_s[MSB], b_s[MSB], res[MSB]);
  end

  // p1: output register stage
  logic signed [data_width-1:0] r_p1;
  logic                         ov_p1;
  logic                         sign_p1;
  logic                         zero_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1    <= '0;
      ov_p1   <= 1'b0;
      sign_p1 <= 1'b0;
      zero_p1 <= 1'b0;
    end else begin
      r_p1    <= res;
      ov_p1   <= ov;
      sign_p1 <= res[MSB];
      zero_p1 <= (res == '0);
    end
  end

  assign R        = r_p1;
  assign ovflag   = ov_p1;
  assign signflag = sign_p1;
  assign zeroflag = zero_p1;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: drivers push expected results computed by an
// arithmetic reference model; per-width monitors pop and compare each cycle.
module tb_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a32 = '0, b32 = '0, r32;
  logic [1:0]  ctl32 = '0;
  logic        ov32, sn32, z32;

  logic [7:0]  a8 = '0, b8 = '0, r8;
  logic [1:0]  ctl8 = '0;
  logic        ov8, sn8, z8;

  alu #(.data_width(32)) dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .control(ctl32),
    .R(r32), .ovflag(ov32), .signflag(sn32), .zeroflag(z32)
  );

  alu #(.data_width(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .control(ctl8),
    .R(r8), .ovflag(ov8), .signflag(sn8), .zeroflag(z8)
  );

  typedef struct {
    logic [31:0] r;
    logic        ov;
    logic        sn;
    logic        z;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference: signed-integer arithmetic with range check for overflow.
  function automatic exp_t model(input longint a, input longint b,
                                 input logic [1:0] op, input int w);
    exp_t   e;
    longint mod, half, sa, sb, s, r;
    mod  = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - mod : a;
    sb   = (b >= half) ? b - mod : b;
    s    = 0;
    e.ov = 1'b0;
    case (op)
      2'd0: begin s = sa + sb; r = (a + b) % mod; end
      2'd1: begin s = sa - sb; r = ((a - b) % mod + mod) % mod; end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    if (op < 2) e.ov = (s >= half) || (s < -half);
    e.r  = 32'(r);
    e.sn = (r >= half);
    e.z  = (r == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] r, input logic ov,
                       input logic sn, input logic z, input exp_t e);
    n_vec++;
    if (r !== e.r || ov !== e.ov || sn !== e.sn || z !== e.z) begin
      n_err++;
      $display("FAIL %s: got R=%h O=%b N=%b Z=%b, want R=%h O=%b N=%b Z=%b",
               name, r, ov, sn, z, e.r, e.ov, e.sn, e.z);
    end
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    a32 = a; b32 = b; ctl32 = op;
    q32.push_back(model(longint'(a), longint'(b), op, 32));
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    @(negedge clk);
    drive32(a, b, op);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge clk);
    a8 = a; b8 = b; ctl8 = op;
    q8.push_back(model(longint'(a), longint'(b), op, 8));
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (q32.size() > 0 || q8.size() > 0); i++) @(posedge clk);
    #2;
    n_vec++;
    if (q32.size() > 0 || q8.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d entries left, want 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q32.size() > 0) check("w32", r32, ov32, sn32, z32, q32.pop_front());
    if (!rst && q8.size() > 0)
      check("w8", {24'd0, r8}, ov8, sn8, z8, q8.pop_front());
  end

  exp_t zero_e;

  initial begin
    zero_e = '{r: 32'd0, ov: 1'b0, sn: 1'b0, z: 1'b0};
    #1;
    check("reset_init", r32, ov32, sn32, z32, zero_e);
    a32 = 32'hFFFFFFFF; b32 = 32'h1; ctl32 = 2'd0;
    @(posedge clk); #1;
    check("reset_hold_edge", r32, ov32, sn32, z32, zero_e);
    @(negedge clk);
    rst = 1'b0;
    drive32(32'hFFFFFFFF, 32'h00000001, 2'd0);

    issue32(32'hAAAAAAAA, 32'hEFABCD19, 2'd0);
    issue32(32'h7FFFFFFF, 32'h00000001, 2'd0);
    issue32(32'h67676767, 32'h12431243, 2'd0);
    issue32(32'hFFFFFFFF, 32'h00000001, 2'd1);
    issue32(32'hFFFFFFFC, 32'hFFFFFFFC, 2'd1);
    issue32(32'h80000000, 32'h00000001, 2'd1);
    issue32(32'hFFFFF000, 32'hFFFFFFFF, 2'd1);
    issue32(32'hABCD4545, 32'h12383588, 2'd2);
    issue32(32'hFFFFFFFF, 32'h0A0AB0B0, 2'd2);
    issue32(32'h00000000, 32'h11000001, 2'd2);
    issue32(32'hF0F0F0F0, 32'hCFCFCFCF, 2'd3);
    issue32(32'hABCD4545, 32'h12383588, 2'd3);
    issue32(32'h00000000, 32'h11000001, 2'd3);
    issue32(32'hAAAAAAAA, 32'hEFABCD19, 2'd0);
    drain();

    // Asynchronous reset with 9A5677C3 held: clear without any clock edge.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("reset_async", r32, ov32, sn32, z32, zero_e);
    @(posedge clk); #1;
    check("reset_held", r32, ov32, sn32, z32, zero_e);
    @(negedge clk);
    rst = 1'b0;
    drive32(32'h80000000, 32'h00000001, 2'd1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = {1'b0, {31{1'b1}}};
        1: b = a;
        default: ;
      endcase
      issue32(a, b, 2'($urandom_range(0, 3)));
    end
    drain();

    issue8(8'h7F, 8'h01, 2'd0);
    issue8(8'h80, 8'h01, 2'd1);
    issue8(8'hFF, 8'h01, 2'd0);
    for (int i = 0; i < 200; i++)
      issue8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
